// File: rtl/inv_request_scheduler.sv
// Round-robin front end that shares one GF(2^163) inversion core among NREQ requesters,
// with zero-operand short-circuit and a bounded wait on the core.
module inv_request_scheduler #(
  parameter int NREQ        = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*163-1:0]  req_operand,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [162:0]         resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 core_start,
  output logic [162:0]         core_operand,
  input  logic                 core_done,
  input  logic [162:0]         core_result
);

  // state | meaning
  // IDLE  | arbitrating; req_ready one-hot toward the round-robin winner
  // ISSUE | one-cycle core_start with the latched operand
  // WAIT  | waiting for core_done, bounded by TIMEOUT_CYC cycles
  // RESP  | result held on resp_* until resp_ready

  localparam int FW    = 163;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cur_id;
  logic [FW-1:0]     op_q;
  logic [FW-1:0]     data_q;
  logic              err_q;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_idx;
  logic              grant_any;
  logic [FW-1:0]     grant_op;
  logic              accept;
  logic              op_zero;
  logic              tmo_hit;

  // Search upward from the requester after the last one served, wrapping at NREQ.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    rr_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = ID_W'((int'(last_grant) + 1 + k) % NREQ);
      if (!grant_any && req_valid[rr_idx]) begin
        grant_any      = 1'b1;
        grant_id       = rr_idx;
        grant[rr_idx]  = 1'b1;
      end
    end
  end

  assign grant_op = req_operand[int'(grant_id)*FW +: FW];
  assign accept   = (state == IDLE) && grant_any;
  assign op_zero  = (grant_op == '0);
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = op_zero ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || tmo_hit) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) ? grant : '0;
    core_start = (state == ISSUE);
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  assign resp_id      = cur_id;
  assign resp_data    = data_q;
  assign resp_err     = err_q;
  assign core_operand = op_q;

  // core_done only counts in WAIT, where it also beats a coincident timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NREQ - 1);
      cur_id     <= '0;
      op_q       <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_id <= grant_id;
            op_q   <= grant_op;
            if (op_zero) begin
              data_q <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (core_done) begin
            data_q <= core_result;
            err_q  <= 1'b0;
          end else if (tmo_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RESP: if (resp_ready) last_grant <= cur_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_request_scheduler.sv
// Self-checking bench for inv_request_scheduler: a behavioural GF(2^163) core model
// plus a round-robin/latency reference, driven by directed and randomized scenarios.
module tb_inv_request_scheduler;
  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam logic [162:0] INV2 = (163'h1 << 162) | 163'h64;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*163-1:0] req_operand;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [1:0]         resp_id;
  logic [162:0]       resp_data;
  logic               resp_err;
  logic               busy;
  logic               core_start;
  logic [162:0]       core_operand;
  logic               core_done;
  logic [162:0]       core_result;

  inv_request_scheduler #(.NREQ(NREQ), .ID_W(2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_operand(req_operand),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .core_start(core_start), .core_operand(core_operand), .core_done(core_done),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int lg;
  logic [162:0] ops [NREQ];

  // core model controls (written by tests) and observations (written by the core model)
  bit core_en  = 1'b1;
  int core_lat = 5;
  int stale_req = 0;
  int stale_ack = 0;
  int cyc = 0;
  int starts = 0;

  function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
    logic [162:0] r;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      r = {r[161:0], 1'b0} ^ (r[162] ? 163'hC9 : 163'h0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // a^(2^163-2) = a^-1 for nonzero a
  function automatic logic [162:0] gf_inv(input logic [162:0] a);
    logic [162:0] r, s;
    if (a == '0) return '0;
    r = 163'h1;
    s = a;
    for (int i = 1; i <= 162; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [162:0] rand_op();
    logic [191:0] w;
    w = '0;
    for (int i = 0; i < 6; i++) w = {w[159:0], 32'($urandom)};
    return w[162:0];
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int j = 1; j <= NREQ; j++)
      if (v[(last + j) % NREQ]) return (last + j) % NREQ;
    return -1;
  endfunction

  initial begin
    bit pend;
    int pend_cnt;
    logic [162:0] pend_res;
    pend = 1'b0; pend_cnt = 0; pend_res = '0;
    core_done = 1'b0; core_result = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      core_done = 1'b0; core_result = '0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin core_done = 1'b1; core_result = pend_res; pend = 1'b0; end
      end
      if (stale_req != stale_ack) begin
        core_done = 1'b1; core_result = rand_op(); stale_ack = stale_req;
      end
      if (core_start === 1'b1) begin
        starts++;
        if (core_en) begin pend = 1'b1; pend_cnt = core_lat; pend_res = gf_inv(core_operand); end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_op(input int i, input logic [162:0] v);
    ops[i] = v;
    req_operand[i*163 +: 163] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    #1 rst = 1'b0;
    tick();
    lg = NREQ - 1;
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (resp_valid === 1'b1) begin got = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0; req_operand = '0;
    for (int i = 0; i < NREQ; i++) ops[i] = '0;
    tick(); tick();
    vectors++; if ({req_ready, resp_valid, resp_err, busy, core_start} !== 8'h0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", {req_ready, resp_valid, resp_err, busy, core_start}); end
    vectors++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", resp_id); end
    vectors++; if (resp_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", resp_data); end
    vectors++; if (core_operand !== '0) begin errors++; $display("FAIL reset_core_operand: got %h want 0", core_operand); end
    rst = 1'b0;
    tick();
    lg = NREQ - 1;
  endtask

  task automatic test_single();
    bit got; int s, n0;
    do_reset();
    core_en = 1'b1; core_lat = 12;
    set_op(0, 163'h2); req_valid = 4'b0001; #1;
    vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick(); req_valid = '0; s = cyc; n0 = starts;
    vectors++; if (core_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", core_start); end
    vectors++; if (core_operand !== 163'h2) begin errors++; $display("FAIL single_operand: got %h want 2", core_operand); end
    wait_resp(got);
    vectors++; if (!got) begin errors++; $display("FAIL single_resp_wait: got none want resp_valid"); end
    vectors++; if (cyc - s !== 13) begin errors++; $display("FAIL single_latency: got %0d want 13", cyc - s); end
    vectors++; if (starts !== n0) begin errors++; $display("FAIL single_start_pulses: got %0d want %0d", starts, n0); end
    vectors++; if (resp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", resp_id); end
    vectors++; if (resp_data !== INV2) begin errors++; $display("FAIL single_data: got %h want %h", resp_data, INV2); end
    vectors++; if (resp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", resp_err); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    vectors++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", {resp_valid, busy}); end
    lg = 0;
  endtask

  task automatic test_round_robin();
    bit got; int ex; logic [162:0] acc;
    int order [6];
    int grants [6];
    order = '{0, 1, 2, 3, 0, 1};
    do_reset();
    core_en = 1'b1; core_lat = 5; resp_ready = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, rand_op() | 163'h1);
      #1;
      ex = rr_pick(lg, req_valid);
      vectors++; if (req_ready !== 4'(1 << ex)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << ex)); end
      grants[k] = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[k] = i;
      acc = ops[ex];
      tick();
      wait_resp(got);
      vectors++; if (!got) begin errors++; $display("FAIL rr_resp_wait%0d: got none want resp_valid", k); end
      vectors++; if (resp_id !== 2'(ex)) begin errors++; $display("FAIL rr_id%0d: got %0d want %0d", k, resp_id, ex); end
      vectors++; if (resp_data !== gf_inv(acc)) begin errors++; $display("FAIL rr_data%0d: got %h want %h", k, resp_data, gf_inv(acc)); end
      tick();
      lg = ex;
    end
    for (int k = 0; k < 6; k++) begin
      vectors++; if (grants[k] !== order[k]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", k, grants[k], order[k]); end
    end
    req_valid = '0; resp_ready = 1'b0;
  endtask

  task automatic test_zero();
    int n0;
    set_op(2, '0); req_valid = 4'b0100; #1;
    vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready: got %b want 0100", req_ready); end
    n0 = starts;
    tick(); req_valid = '0;
    vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL zero_latency: got %b want 1", resp_valid); end
    vectors++; if ({resp_id, resp_err} !== 3'b101) begin errors++; $display("FAIL zero_id_err: got %b want 101", {resp_id, resp_err}); end
    vectors++; if (resp_data !== '0) begin errors++; $display("FAIL zero_data: got %h want 0", resp_data); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0; tick();
    vectors++; if (starts !== n0) begin errors++; $display("FAIL zero_no_start: got %0d want %0d", starts, n0); end
    lg = 2;
  endtask

  task automatic test_timeout();
    bit got; int s;
    core_en = 1'b0;
    set_op(1, rand_op() | 163'h1); req_valid = 4'b0010; #1;
    tick(); req_valid = '0; s = cyc;
    vectors++; if (core_start !== 1'b1) begin errors++; $display("FAIL tmo_start: got %b want 1", core_start); end
    wait_resp(got);
    vectors++; if (!got) begin errors++; $display("FAIL tmo_resp_wait: got none want resp_valid"); end
    vectors++; if (cyc - s !== TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", cyc - s, TMO + 1); end
    vectors++; if ({resp_id, resp_err} !== 3'b011) begin errors++; $display("FAIL tmo_id_err: got %b want 011", {resp_id, resp_err}); end
    stale_req++; tick(); tick();
    vectors++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("FAIL tmo_late_done_flags: got %b want 11", {resp_valid, resp_err}); end
    vectors++; if (resp_data !== '0) begin errors++; $display("FAIL tmo_late_done_data: got %h want 0", resp_data); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    stale_req++; tick(); tick();
    vectors++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL tmo_idle_done: got %b want 00", {resp_valid, busy}); end
    core_en = 1'b1; lg = 1;
  endtask

  task automatic test_backpressure();
    bit got; int ex; logic [162:0] acc;
    do_reset();
    core_en = 1'b1; core_lat = 3;
    set_op(0, rand_op() | 163'h1); acc = ops[0]; req_valid = 4'b0001; #1;
    tick();
    set_op(1, rand_op() | 163'h1); set_op(3, rand_op() | 163'h1); req_valid = 4'b1010;
    wait_resp(got);
    vectors++; if (!got) begin errors++; $display("FAIL bp_resp_wait: got none want resp_valid"); end
    for (int c = 0; c < 5; c++) begin
      vectors++; if ({resp_valid, busy, resp_id, resp_err} !== 5'b11000 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ctrl%0d: got %b/%b want 11000/0000", c, {resp_valid, busy, resp_id, resp_err}, req_ready); end
      vectors++; if (resp_data !== gf_inv(acc)) begin errors++; $display("FAIL bp_hold_data%0d: got %h want %h", c, resp_data, gf_inv(acc)); end
      tick();
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0; lg = 0;
    for (int n = 0; n < 2; n++) begin
      ex = rr_pick(lg, req_valid);
      vectors++; if (req_ready !== 4'(1 << ex)) begin errors++; $display("FAIL bp_next_grant%0d: got %b want %b", n, req_ready, 4'(1 << ex)); end
      acc = ops[ex];
      tick();
      wait_resp(got);
      vectors++; if (!got || resp_id !== 2'(ex)) begin errors++; $display("FAIL bp_next_id%0d: got %0d want %0d", n, resp_id, ex); end
      vectors++; if (resp_data !== gf_inv(acc)) begin errors++; $display("FAIL bp_next_data%0d: got %h want %h", n, resp_data, gf_inv(acc)); end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0; lg = ex;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midwait();
    bit got; logic [162:0] acc;
    set_op(1, '0); req_valid = 4'b0010; #1;
    tick(); req_valid = '0;
    resp_ready = 1'b1; tick(); resp_ready = 1'b0; lg = 1;
    core_en = 1'b0;
    set_op(2, rand_op() | 163'h1); req_valid = 4'b0100; #1;
    tick(); req_valid = '0; tick(); tick();
    rst = 1'b1; #1;
    vectors++; if ({req_ready, resp_valid, resp_err, busy, core_start} !== 8'h0) begin errors++; $display("FAIL midrst_ctrl: got %b want 0", {req_ready, resp_valid, resp_err, busy, core_start}); end
    vectors++; if (resp_id !== 2'd0 || resp_data !== '0 || core_operand !== '0) begin errors++; $display("FAIL midrst_data: got %0d/%h/%h want 0/0/0", resp_id, resp_data, core_operand); end
    tick(); rst = 1'b0; lg = NREQ - 1;
    tick(); tick(); stale_req++;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL midrst_stale%0d: got %b want 00", c, {resp_valid, busy}); end
    end
    core_en = 1'b1; core_lat = 4;
    for (int i = 0; i < NREQ; i++) set_op(i, rand_op() | 163'h1);
    req_valid = 4'b1111; #1;
    vectors++; if (req_ready !== 4'(1 << rr_pick(lg, req_valid))) begin errors++; $display("FAIL midrst_priority: got %b want %b", req_ready, 4'(1 << rr_pick(lg, req_valid))); end
    acc = ops[0];
    tick(); req_valid = '0;
    wait_resp(got);
    vectors++; if (!got || resp_id !== 2'd0 || resp_data !== gf_inv(acc)) begin errors++; $display("FAIL midrst_first: got %0d/%h want 0/%h", resp_id, resp_data, gf_inv(acc)); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0; lg = 0;
  endtask

  task automatic test_random();
    bit got, en; int ex, lat, s, n0, hold; logic [162:0] acc, exp_data; logic exp_err; logic [NREQ-1:0] mask;
    for (int t = 0; t < 30; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) set_op(i, ($urandom_range(0, 3) == 0) ? 163'h0 : (rand_op() | 163'h1));
      en = ($urandom_range(0, 5) != 0); lat = $urandom_range(1, TMO);
      core_en = en; core_lat = lat;
      req_valid = mask; #1;
      ex = rr_pick(lg, mask);
      vectors++; if (req_ready !== 4'(1 << ex)) begin errors++; $display("FAIL rand_grant%0d: got %b want %b", t, req_ready, 4'(1 << ex)); end
      acc = ops[ex];
      tick(); s = cyc; n0 = starts;
      vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rand_busy_ready%0d: got %b want 0000", t, req_ready); end
      if (acc == '0) begin
        vectors++; if ({resp_valid, core_start} !== 2'b10) begin errors++; $display("FAIL rand_zero%0d: got %b want 10", t, {resp_valid, core_start}); end
        exp_data = '0; exp_err = 1'b1;
      end else begin
        vectors++; if (core_start !== 1'b1) begin errors++; $display("FAIL rand_start%0d: got %b want 1", t, core_start); end
        wait_resp(got);
        vectors++; if (!got || cyc - s !== (en ? lat + 1 : TMO + 1)) begin errors++; $display("FAIL rand_latency%0d: got %0d want %0d", t, cyc - s, en ? lat + 1 : TMO + 1); end
        exp_data = en ? gf_inv(acc) : '0; exp_err = !en;
      end
      vectors++; if (resp_id !== 2'(ex) || resp_err !== exp_err) begin errors++; $display("FAIL rand_id_err%0d: got %0d/%b want %0d/%b", t, resp_id, resp_err, ex, exp_err); end
      vectors++; if (resp_data !== exp_data) begin errors++; $display("FAIL rand_data%0d: got %h want %h", t, resp_data, exp_data); end
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      vectors++; if (starts !== n0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rand_done%0d: got %0d/%b want %0d/0", t, starts, resp_valid, n0); end
      lg = ex;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero();
    test_timeout();
    test_backpressure();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1);
  end
endmodule
